// File: rtl/lcv_mul_acc_pkg.sv
// Shared types and default widths for the lcv_mul_acc_pipe signed multiply-accumulate.
// Purely declarative: no logic, no latency, no flow control.
package lcv_mul_acc_pkg;

  typedef enum logic {OP_MAC = 1'b0, OP_MSUB = 1'b1} op_e;

  localparam int DEF_A_WIDTH   = 16;
  localparam int DEF_B_WIDTH   = 16;
  localparam int DEF_C_WIDTH   = 33;
  localparam int DEF_ACC_WIDTH = 40;

  // The accumulator must hold any single product plus sign, and any addend.
  function automatic bit widths_ok(input int a_w, input int b_w, input int c_w, input int acc_w);
    return (acc_w >= a_w + b_w + 1) && (acc_w >= c_w);
  endfunction

endpackage

// File: rtl/lcv_mul_acc_pipe_mul.sv
// Operand (S1) and product (S2) stages of the MAC pipeline; 2 cycles from i_vld to o_vld.
// Every register advances only while i_en is high, so a downstream stall freezes both stages.
module lcv_mul_acc_pipe_mul
  import lcv_mul_acc_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int C_WIDTH = DEF_C_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic                       i_vld,
  input  logic [A_WIDTH-1:0]         i_a,
  input  logic [B_WIDTH-1:0]         i_b,
  input  logic [C_WIDTH-1:0]         i_c,
  input  op_e                        i_op,
  input  logic                       i_first,
  input  logic                       i_last,
  output logic                       o_vld,
  output logic [A_WIDTH+B_WIDTH-1:0] o_p,
  output logic [C_WIDTH-1:0]         o_c,
  output op_e                        o_op,
  output logic                       o_first,
  output logic                       o_last
);

  localparam int PW = A_WIDTH + B_WIDTH;

  logic                      r_s1_vld;
  logic                      r_s2_vld;
  logic signed [A_WIDTH-1:0] r_a;
  logic signed [B_WIDTH-1:0] r_b;
  logic [C_WIDTH-1:0]        r_s1_c;
  logic [C_WIDTH-1:0]        r_s2_c;
  op_e                       r_s1_op;
  op_e                       r_s2_op;
  logic                      r_s1_first;
  logic                      r_s2_first;
  logic                      r_s1_last;
  logic                      r_s2_last;
  (* use_dsp48 = "yes" *)
  logic signed [PW-1:0]      r_p;
  logic signed [PW-1:0]      w_a_ext;
  logic signed [PW-1:0]      w_b_ext;

  assign w_a_ext = PW'(r_a);
  assign w_b_ext = PW'(r_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else if (i_en) begin
      r_s1_vld <= i_vld;
      r_s2_vld <= r_s1_vld;
    end
  end

  // Datapath registers carry no reset so the operand/product regs can pack into the DSP slice.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_a        <= i_a;
      r_b        <= i_b;
      r_s1_c     <= i_c;
      r_s1_op    <= i_op;
      r_s1_first <= i_first;
      r_s1_last  <= i_last;
      r_p        <= w_a_ext * w_b_ext;
      r_s2_c     <= r_s1_c;
      r_s2_op    <= r_s1_op;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
    end
  end

  assign o_vld   = r_s2_vld;
  assign o_p     = r_p;
  assign o_c     = r_s2_c;
  assign o_op    = r_s2_op;
  assign o_first = r_s2_first;
  assign o_last  = r_s2_last;

endmodule

// File: rtl/lcv_mul_acc_pipe.sv
// Framed signed multiply-accumulate: sum(+/-a*b + c) from first..last, one result per sequence.
// Latency 3 edges from last-term acceptance to out_valid; 1 term/clk; one global stall when out_valid && !out_ready.
// LCV_MUL_ACC_PIPE_SAT_EN: saturate instead of wrap on accumulator overflow (out_ovf reported either way).
module lcv_mul_acc_pipe
  import lcv_mul_acc_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int C_WIDTH   = DEF_C_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic [C_WIDTH-1:0]   in_c,
  input  op_e                  in_op,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int SW = ACC_WIDTH + 2;

  if (!widths_ok(A_WIDTH, B_WIDTH, C_WIDTH, ACC_WIDTH)) begin : g_width_check
    $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH+1 and >= C_WIDTH");
  end

  logic                    w_adv;
  logic                    w_s2_vld;
  logic [PW-1:0]           w_s2_p;
  logic [C_WIDTH-1:0]      w_s2_c;
  op_e                     w_s2_op;
  logic                    w_s2_first;
  logic                    w_s2_last;
  logic signed [SW-1:0]    w_p_ext;
  logic signed [SW-1:0]    w_c_ext;
  logic signed [SW-1:0]    w_term;
  logic signed [SW-1:0]    w_base;
  logic signed [SW-1:0]    w_sum;
  logic                    w_of;
  logic                    w_ovf_next;
  logic [ACC_WIDTH-1:0]    w_acc_next;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                    r_ovf;
  logic                    r_out_vld;
  logic [ACC_WIDTH-1:0]    r_out_dat;
  logic                    r_out_ovf;

  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = rst && w_adv;

  lcv_mul_acc_pipe_mul #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .C_WIDTH (C_WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_adv),
    .i_vld   (in_valid),
    .i_a     (in_a),
    .i_b     (in_b),
    .i_c     (in_c),
    .i_op    (in_op),
    .i_first (in_first),
    .i_last  (in_last),
    .o_vld   (w_s2_vld),
    .o_p     (w_s2_p),
    .o_c     (w_s2_c),
    .o_op    (w_s2_op),
    .o_first (w_s2_first),
    .o_last  (w_s2_last)
  );

  // Two guard bits cover base + product + addend without losing the true sign.
  assign w_p_ext    = SW'($signed(w_s2_p));
  assign w_c_ext    = SW'($signed(w_s2_c));
  assign w_term     = (w_s2_op == OP_MSUB) ? (w_c_ext - w_p_ext) : (w_c_ext + w_p_ext);
  assign w_base     = w_s2_first ? '0 : SW'(r_acc);
  assign w_sum      = w_base + w_term;
  assign w_of       = (w_sum[SW-1:ACC_WIDTH-1] != {3{w_sum[SW-1]}});
  assign w_ovf_next = (w_s2_first ? 1'b0 : r_ovf) | w_of;

`ifdef LCV_MUL_ACC_PIPE_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign w_acc_next = w_of ? (w_sum[SW-1] ? ACC_MIN : ACC_MAX) : w_sum[ACC_WIDTH-1:0];
`else
  assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= w_s2_vld && w_s2_last;
      if (w_s2_vld) begin
        if (w_s2_last) begin
          r_out_dat <= w_acc_next;
          r_out_ovf <= w_ovf_next;
          r_acc     <= '0;
          r_ovf     <= 1'b0;
        end else begin
          r_acc     <= w_acc_next;
          r_ovf     <= w_ovf_next;
        end
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Bench for lcv_mul_acc_pipe: 40-bit and 33-bit accumulator instances share one input stream.
// Directed table + hand sequences, then random traffic against an arithmetic reference model.
module tb_lcv_mul_acc_pipe;
  import lcv_mul_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        ir33;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [32:0] in_c;
  op_e         in_op;
  logic        in_first;
  logic        in_last;
  logic        out_ready;
  logic        ov40;
  logic        ov33;
  logic [39:0] od40;
  logic [32:0] od33;
  logic        of40;
  logic        of33;

  always #5 clk = ~clk;

  lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .C_WIDTH(33), .ACC_WIDTH(40)) dut40 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
    .in_first(in_first), .in_last(in_last),
    .out_valid(ov40), .out_ready(out_ready), .out_data(od40), .out_ovf(of40)
  );

  lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .C_WIDTH(33), .ACC_WIDTH(33)) dut33 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir33),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
    .in_first(in_first), .in_last(in_last),
    .out_valid(ov33), .out_ready(out_ready), .out_data(od33), .out_ovf(of33)
  );

  typedef struct {
    longint data;
    bit     ovf;
  } res_t;

  typedef struct {
    int     a;
    int     b;
    longint c;
    bit     op;
    bit     f;
    bit     l;
    longint exp;
    bit     eovf;
  } vec_t;

  int     vectors = 0;
  int     miscompares = 0;
  res_t   got0[$];
  res_t   got1[$];
  res_t   exp0[$];
  res_t   exp1[$];
  longint m_acc[2];
  bit     m_ovf[2];
  res_t   mon_r;

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: exact integer sum per term, then range-check against the accumulator width.
  function automatic void model_term(input longint a, input longint b, input longint c,
                                     input bit op, input bit f, input bit l);
    longint t, s, mx, mn;
    int w;
    res_t r;
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? 40 : 33;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -mx - 1;
      if (f) begin
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end
      t = op ? -(a * b) : (a * b);
      s = m_acc[k] + t + c;
      if (s > mx || s < mn) begin
        m_ovf[k] = 1'b1;
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
        s = (s > mx) ? mx : mn;
`else
        s = (s <<< (64 - w)) >>> (64 - w);
`endif
      end
      m_acc[k] = s;
      if (l) begin
        r.data = s;
        r.ovf  = m_ovf[k];
        if (k == 0) exp0.push_back(r);
        else        exp1.push_back(r);
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      m_acc[0] = 0; m_acc[1] = 0;
      m_ovf[0] = 0; m_ovf[1] = 0;
    end else begin
      if (in_valid && in_ready)
        model_term(longint'($signed(in_a)), longint'($signed(in_b)), longint'($signed(in_c)),
                   in_op == OP_MSUB, in_first, in_last);
      if (ov40 && out_ready) begin
        mon_r.data = longint'($signed(od40));
        mon_r.ovf  = of40;
        got0.push_back(mon_r);
      end
      if (ov33 && out_ready) begin
        mon_r.data = longint'($signed(od33));
        mon_r.ovf  = of33;
        got1.push_back(mon_r);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int a, input int b, input longint c, input bit op, input bit f, input bit l);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_c     = 33'(c);
    in_op    = op_e'(op);
    in_first = f;
    in_last  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout_accepted", 0, 1);
  endtask

  task automatic drain_check(input string tag);
    res_t g, e;
    chk({tag, "_count40"}, got0.size(), exp0.size());
    chk({tag, "_count33"}, got1.size(), exp1.size());
    while (got0.size() > 0 && exp0.size() > 0) begin
      g = got0.pop_front();
      e = exp0.pop_front();
      chk({tag, "_data40"}, g.data, e.data);
      chk({tag, "_ovf40"}, longint'(g.ovf), longint'(e.ovf));
    end
    while (got1.size() > 0 && exp1.size() > 0) begin
      g = got1.pop_front();
      e = exp1.pop_front();
      chk({tag, "_data33"}, g.data, e.data);
      chk({tag, "_ovf33"}, longint'(g.ovf), longint'(e.ovf));
    end
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    int   nlast;
    int   k;

    tbl[0]  = '{3, -4, 5, 1'b0, 1'b1, 1'b1, -7, 1'b0};
    tbl[1]  = '{1, 2, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[2]  = '{3, 4, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[3]  = '{5, 6, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[4]  = '{7, 8, 0, 1'b0, 1'b0, 1'b1, 100, 1'b0};
    tbl[5]  = '{10, 10, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[6]  = '{2, 3, 0, 1'b1, 1'b0, 1'b1, 95, 1'b0};
    tbl[7]  = '{2, 3, 1, 1'b0, 1'b0, 1'b1, 7, 1'b0};
    tbl[8]  = '{100, 100, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[9]  = '{4, 5, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[10] = '{1, 1, -3, 1'b0, 1'b0, 1'b1, 18, 1'b0};
    tbl[11] = '{-32768, -32768, -5, 1'b1, 1'b1, 1'b1, -1073741829, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    in_op = OP_MAC; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    @(negedge clk);
    chk("reset_out_valid", longint'(ov40), 0);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_out_data", longint'(od40), 0);
    chk("reset_out_ovf", longint'(of40), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", longint'(in_ready), 1);
    cycles(1);

    // Single term: result appears exactly 3 edges after acceptance.
    send(3, -4, 5, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_valid", longint'(ov40), 0);
    @(negedge clk);
    chk("lat_edge2_valid", longint'(ov40), 0);
    @(negedge clk);
    chk("lat_edge3_valid", longint'(ov40), 1);
    chk("lat_edge3_data", longint'($signed(od40)), -7);
    chk("lat_edge3_ovf", longint'(of40), 0);
    cycles(3);
    drain_check("single");

    // Directed table, back-to-back terms.
    nlast = 0;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].op, tbl[i].f, tbl[i].l);
      if (tbl[i].l) nlast++;
    end
    in_valid = 1'b0;
    cycles(8);
    chk("table_result_count", got0.size(), nlast);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].l) begin
        if (k < got0.size()) begin
          chk($sformatf("table_%0d_data", i), got0[k].data, tbl[i].exp);
          chk($sformatf("table_%0d_ovf", i), longint'(got0[k].ovf), longint'(tbl[i].eovf));
        end
        k++;
      end
    end
    drain_check("table");

    // Five terms of 2^30: fits 40 bits, overflows the 33-bit instance.
    for (int i = 0; i < 5; i++) send(-32768, -32768, 0, 1'b0, i == 0, i == 4);
    in_valid = 1'b0;
    cycles(8);
    chk("ovf_count40", got0.size(), 1);
    chk("ovf_count33", got1.size(), 1);
    if (got0.size() > 0) begin
      chk("ovf40_data", got0[0].data, 64'sd5368709120);
      chk("ovf40_flag", longint'(got0[0].ovf), 0);
    end
    if (got1.size() > 0) begin
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
      chk("ovf33_data", got1[0].data, 64'sd4294967295);
`else
      chk("ovf33_data", got1[0].data, -64'sd3221225472);
`endif
      chk("ovf33_flag", longint'(got1[0].ovf), 1);
    end
    drain_check("ovf");

    // Backpressure with two sequences in flight and a third offered.
    out_ready = 1'b0;
    send(1, 1, 0, 1'b0, 1'b1, 1'b0);
    send(2, 2, 0, 1'b0, 1'b0, 1'b1);
    send(3, 3, 0, 1'b0, 1'b1, 1'b0);
    send(4, 4, 0, 1'b0, 1'b0, 1'b1);
    in_a = 16'd5; in_b = 16'd6; in_c = '0; in_first = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_out_valid", longint'(ov40), 1);
      chk("stall_out_data", longint'($signed(od40)), 5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(5, 6, 0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    cycles(8);
    chk("bp_count", got0.size(), 3);
    if (got0.size() == 3) begin
      chk("bp_order0", got0[0].data, 5);
      chk("bp_order1", got0[1].data, 25);
      chk("bp_order2", got0[2].data, 30);
    end
    drain_check("bp");

    // Reset mid-sequence while a result is held: everything clears asynchronously.
    out_ready = 1'b0;
    send(3, 3, 0, 1'b0, 1'b1, 1'b1);
    send(1, 1, 0, 1'b0, 1'b1, 1'b0);
    send(1, 1, 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    cycles(2);
    chk("pre_reset_valid", longint'(ov40), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_valid", longint'(ov40), 0);
    chk("async_reset_data", longint'(od40), 0);
    chk("async_reset_ovf", longint'(of40), 0);
    chk("async_reset_in_ready", longint'(in_ready), 0);
    cycles(2);
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    #2;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    send(6, 7, -2, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    cycles(6);
    chk("post_reset_count", got0.size(), 1);
    if (got0.size() > 0) chk("post_reset_data", got0[0].data, 40);
    drain_check("post_reset");

    // Random traffic with bubbles and random downstream stalls.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_c      = 33'({$urandom, $urandom});
      in_op     = op_e'($urandom % 2);
      in_first  = ($urandom % 4) == 0;
      in_last   = ($urandom % 4) == 0;
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(10);
    drain_check("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
